serializer: RTL

Parallel-in, serial-out transmitter: accepts an `n`-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per enabled clock, with a qualifying valid flag and an end-of-word pulse. It is the sending end of the register path built from the `dff` storage element. Its intended consumer is a deserializer or a capture register clocked by the shared `clock` block.

---
 rtl/serializer.sv | 44 ++++
 1 files changed

// File: rtl/serializer.sv
// serializer: valid/ready loaded parallel word shifted out MSB-first, one bit per enabled clock.
module serializer #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] d,
  input  logic         valid,
  output logic         ready,
  input  logic         enable,
  output logic         q,
  output logic         q_valid,
  output logic         done
);
  localparam int cw = n > 1 ? $clog2(n) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [n-1:0] shreg_q, shreg_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic load, step, last;
  always_comb begin
    load = state_q == S_IDLE && valid && !reset;
    step = state_q == S_SHIFT && enable;
    last = cnt_q == cw'(n - 1);
    state_d = load ? S_SHIFT : step && last ? S_DONE : state_q == S_DONE ? S_IDLE : state_q;
    shreg_d = load ? d : step && !last ? shreg_q << 1 : shreg_q;
    cnt_d = load ? '0 : step && !last ? cnt_q + cw'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
    end
  end
  assign ready = state_q == S_IDLE && !reset;
  assign q_valid = state_q == S_SHIFT;
  assign q = state_q == S_SHIFT && shreg_q[n-1];
  assign done = state_q == S_DONE;
endmodule
